// File: rtl/dr_channel_scheduler_pkg.sv
// Shared definitions for the dual-rail channel scheduler: level constants,
// FSM state encodings and the spacer (return-to-zero) rail value.
package dr_channel_scheduler_pkg;

   localparam logic ON  = 1'b1;
   localparam logic OFF = 1'b0;

   localparam int unsigned ST_W = 2;
   localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
   localparam logic [ST_W-1:0] ST_DATA = 2'd1;
   localparam logic [ST_W-1:0] ST_NULL = 2'd2;

   // Every rail low is the four-phase spacer between codewords.
   localparam logic SPACER_BIT = 1'b0;

endpackage

// File: rtl/dr_channel_scheduler_rr_picker.sv
// Combinational round-robin select: first asserted request at or after the
// pointer, searching cyclically. Wrap uses a compare, so any N_REQ works.
module dr_channel_scheduler_rr_picker
   import dr_channel_scheduler_pkg::*;
#(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             found_o
);

   int unsigned j;

   // Scan all offsets from the pointer; the earliest hit wins.
   always_comb begin
      idx_o   = '0;
      found_o = OFF;
      j       = 0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         j = 32'(ptr_i) + i;
         if (j >= N_REQ) begin
            j = j - N_REQ;
         end
         if (!found_o && req_i[j[IDX_W-1:0]]) begin
            found_o = ON;
            idx_o   = j[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/dr_channel_scheduler.sv
// Shares one dual-rail four-phase handshake stage among N_REQ single-rail
// requesters: arbitrate, drive codeword, wait ack, drive spacer, wait ack low.
module dr_channel_scheduler
   import dr_channel_scheduler_pkg::*;
#(
   parameter int unsigned N_REQ       = 4,
   parameter int unsigned BIT0        = 8,
   parameter int unsigned BIT1        = 16,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT     = 255
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ*BIT0-1:0]     data0,
   input  logic [N_REQ*BIT1-1:0]     data1,
   output logic [N_REQ-1:0]          gnt,
   output logic [$clog2(N_REQ)-1:0]  grant_id,
   output logic [BIT0-1:0]           dt_0,
   output logic [BIT0-1:0]           df_0,
   output logic [BIT1-1:0]           dt_1,
   output logic [BIT1-1:0]           df_1,
   input  logic                      ack_prev,
   output logic                      busy,
   output logic                      timeout_err,
   input  logic                      clear_err
);

   localparam int unsigned IDX_W = $clog2(N_REQ);
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   ack_s;

   logic [ST_W-1:0]  state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d, gid_q, gid_d, ptr_nxt;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [BIT0-1:0]  dt0_q, dt0_d, df0_q, df0_d, sel0;
   logic [BIT1-1:0]  dt1_q, dt1_d, df1_q, df1_d, sel1;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic             err_q, err_d, busy_q, busy_d;

   logic [IDX_W-1:0] pick_idx;
   logic             pick_found;

   // Ack synchronizer chain; only the last stage feeds decisions.
   for (genvar g = 0; g < SYNC_STAGES; g++) begin : g_sync
      if (g == 0) begin : g_first
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) sync_q[g] <= OFF;
            else          sync_q[g] <= ack_prev;
         end
      end else begin : g_rest
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) sync_q[g] <= OFF;
            else          sync_q[g] <= sync_q[g-1];
         end
      end
   end
   assign ack_s = sync_q[SYNC_STAGES-1];

   dr_channel_scheduler_rr_picker #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_picker (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .idx_o   (pick_idx),
      .found_o (pick_found)
   );

   assign sel0    = data0[pick_idx*BIT0 +: BIT0];
   assign sel1    = data1[pick_idx*BIT1 +: BIT1];
   assign ptr_nxt = (gid_q == IDX_W'(N_REQ - 1)) ? '0 : gid_q + 1'b1;

   // Handshake sequencing: next state, rails, grant pulse, counter and error.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gid_d   = gid_q;
      cnt_d   = cnt_q;
      dt0_d   = dt0_q;
      df0_d   = df0_q;
      dt1_d   = dt1_q;
      df1_d   = df1_q;
      gnt_d   = '0;
      err_d   = clear_err ? OFF : err_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_found && !ack_s) begin
               state_d = ST_DATA;
               gid_d   = pick_idx;
               cnt_d   = '0;
               dt0_d   = sel0;
               df0_d   = ~sel0;
               dt1_d   = sel1;
               df1_d   = ~sel1;
            end
         end
         ST_DATA: begin
            if (ack_s || cnt_q == TO_CNT) begin
               state_d = ST_NULL;
               cnt_d   = '0;
               dt0_d   = {BIT0{SPACER_BIT}};
               df0_d   = {BIT0{SPACER_BIT}};
               dt1_d   = {BIT1{SPACER_BIT}};
               df1_d   = {BIT1{SPACER_BIT}};
               if (ack_s) gnt_d[gid_q] = ON;
               else       err_d        = ON;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_NULL: begin
            if (!ack_s || cnt_q == TO_CNT) begin
               state_d = ST_IDLE;
               ptr_d   = ptr_nxt;
               cnt_d   = '0;
               if (ack_s) err_d = ON;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            dt0_d   = {BIT0{SPACER_BIT}};
            df0_d   = {BIT0{SPACER_BIT}};
            dt1_d   = {BIT1{SPACER_BIT}};
            df1_d   = {BIT1{SPACER_BIT}};
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers; reset forces the spacer immediately.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         gid_q   <= '0;
         cnt_q   <= '0;
         dt0_q   <= '0;
         df0_q   <= '0;
         dt1_q   <= '0;
         df1_q   <= '0;
         gnt_q   <= '0;
         err_q   <= OFF;
         busy_q  <= OFF;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gid_q   <= gid_d;
         cnt_q   <= cnt_d;
         dt0_q   <= dt0_d;
         df0_q   <= df0_d;
         dt1_q   <= dt1_d;
         df1_q   <= df1_d;
         gnt_q   <= gnt_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
      end
   end

   assign gnt         = gnt_q;
   assign grant_id    = gid_q;
   assign dt_0        = dt0_q;
   assign df_0        = df0_q;
   assign dt_1        = dt1_q;
   assign df_1        = df1_q;
   assign busy        = busy_q;
   assign timeout_err = err_q;

endmodule

// File: tb/tb_dr_channel_scheduler.sv
// Directed bench for dr_channel_scheduler with a behavioural four-phase stage.
module tb_dr_channel_scheduler;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [3:0]  req = '0;
   logic [31:0] data0;
   logic [63:0] data1;
   logic [3:0]  gnt;
   logic [1:0]  grant_id;
   logic [7:0]  dt_0, df_0;
   logic [15:0] dt_1, df_1;
   logic        ack_prev;
   logic        busy, timeout_err;
   logic        clear_err = 1'b0;

   logic        ack_model = 1'b0;
   int          mcnt = 0;
   logic        force_en = 1'b0;
   logic        force_val = 1'b0;

   int tests = 0;
   int failed = 0;

   assign ack_prev = force_en ? force_val : ack_model;
   assign data0 = {8'hF0, 8'hA5, 8'h3C, 8'h11};
   assign data1 = {16'h8000, 16'h1234, 16'hBEEF, 16'h0001};

   always #5 clk = ~clk;

   dr_channel_scheduler #(
      .N_REQ       (4),
      .BIT0        (8),
      .BIT1        (16),
      .SYNC_STAGES (2),
      .TIMEOUT     (8)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req         (req),
      .data0       (data0),
      .data1       (data1),
      .gnt         (gnt),
      .grant_id    (grant_id),
      .dt_0        (dt_0),
      .df_0        (df_0),
      .dt_1        (dt_1),
      .df_1        (df_1),
      .ack_prev    (ack_prev),
      .busy        (busy),
      .timeout_err (timeout_err),
      .clear_err   (clear_err)
   );

   // Stage model: ack follows codeword presence three cycles later.
   always @(negedge clk) begin
      logic cw;
      cw = |{dt_0, df_0, dt_1, df_1};
      if (cw != ack_model) begin
         mcnt = mcnt + 1;
         if (mcnt == 3) begin
            ack_model = cw;
            mcnt = 0;
         end
      end else begin
         mcnt = 0;
      end
   end

   typedef struct {
      logic [3:0]  req;
      logic [1:0]  id;
      logic [3:0]  gnt;
      logic [7:0]  dt0;
      logic [7:0]  df0;
      logic [15:0] dt1;
      logic [15:0] df1;
      int          mode;   // 0 hold req, 1 drop after gnt, 2 drop during DATA
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic spacer();
      return ({dt_0, df_0, dt_1, df_1} == '0);
   endfunction

   task automatic wait_busy(input logic level, input string name);
      int n;
      n = 0;
      while (busy !== level && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk(name, 32'(busy), 32'(level));
   endtask

   task automatic wait_gnt(input string name);
      int n;
      n = 0;
      while (gnt == '0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk(name, 32'(n < 60), 32'd1);
   endtask

   task automatic do_xfer(input vec_t v, input int k);
      req = v.req;
      if (busy) @(negedge clk);
      wait_busy(1'b1, $sformatf("v%0d_start", k));
      chk($sformatf("v%0d_id", k), 32'(grant_id), 32'(v.id));
      chk($sformatf("v%0d_dt0", k), 32'(dt_0), 32'(v.dt0));
      chk($sformatf("v%0d_df0", k), 32'(df_0), 32'(v.df0));
      chk($sformatf("v%0d_dt1", k), 32'(dt_1), 32'(v.dt1));
      chk($sformatf("v%0d_df1", k), 32'(df_1), 32'(v.df1));
      if (v.mode == 2) req = '0;
      wait_gnt($sformatf("v%0d_gnt_seen", k));
      chk($sformatf("v%0d_gnt", k), 32'(gnt), 32'(v.gnt));
      chk($sformatf("v%0d_spacer_at_gnt", k), 32'(spacer()), 32'd1);
      @(negedge clk);
      chk($sformatf("v%0d_gnt_pulse", k), 32'(gnt), 32'd0);
      if (v.mode != 0) req = '0;
      wait_busy(1'b0, $sformatf("v%0d_idle", k));
   endtask

   initial begin
      int n, dcount, bad, gseen;

      vecs[0]  = '{4'b0100, 2'd2, 4'b0100, 8'hA5, 8'h5A, 16'h1234, 16'hEDCB, 1};
      vecs[1]  = '{4'b1111, 2'd3, 4'b1000, 8'hF0, 8'h0F, 16'h8000, 16'h7FFF, 0};
      vecs[2]  = '{4'b1111, 2'd0, 4'b0001, 8'h11, 8'hEE, 16'h0001, 16'hFFFE, 0};
      vecs[3]  = '{4'b1111, 2'd1, 4'b0010, 8'h3C, 8'hC3, 16'hBEEF, 16'h4110, 0};
      vecs[4]  = '{4'b1111, 2'd2, 4'b0100, 8'hA5, 8'h5A, 16'h1234, 16'hEDCB, 0};
      vecs[5]  = '{4'b1111, 2'd3, 4'b1000, 8'hF0, 8'h0F, 16'h8000, 16'h7FFF, 0};
      vecs[6]  = '{4'b1111, 2'd0, 4'b0001, 8'h11, 8'hEE, 16'h0001, 16'hFFFE, 1};
      vecs[7]  = '{4'b1010, 2'd1, 4'b0010, 8'h3C, 8'hC3, 16'hBEEF, 16'h4110, 1};
      vecs[8]  = '{4'b1001, 2'd3, 4'b1000, 8'hF0, 8'h0F, 16'h8000, 16'h7FFF, 1};
      vecs[9]  = '{4'b0110, 2'd1, 4'b0010, 8'h3C, 8'hC3, 16'hBEEF, 16'h4110, 1};
      vecs[10] = '{4'b0011, 2'd0, 4'b0001, 8'h11, 8'hEE, 16'h0001, 16'hFFFE, 1};
      vecs[11] = '{4'b0100, 2'd2, 4'b0100, 8'hA5, 8'h5A, 16'h1234, 16'hEDCB, 2};
      vecs[12] = '{4'b0001, 2'd0, 4'b0001, 8'h11, 8'hEE, 16'h0001, 16'hFFFE, 1};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_spacer", 32'(spacer()), 32'd1);
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_id", 32'(grant_id), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err", 32'(timeout_err), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 13; i++) do_xfer(vecs[i], i);

      // Timeout with ack held low; pointer is 1 so requester 0 is picked.
      force_en = 1'b1;
      force_val = 1'b0;
      gseen = 0;
      req = 4'b0001;
      wait_busy(1'b1, "to_start");
      dcount = 0;
      n = 0;
      while (!timeout_err && n < 40) begin
         if (busy) dcount++;
         if (gnt != '0) gseen++;
         @(negedge clk);
         n++;
      end
      chk("to_err_set", 32'(timeout_err), 32'd1);
      chk("to_data_cycles", 32'(dcount >= 8 && dcount <= 9), 32'd1);
      chk("to_spacer", 32'(spacer()), 32'd1);
      clear_err = 1'b1;
      @(negedge clk);
      chk("to_clear", 32'(timeout_err), 32'd0);
      n = 0;
      while (!timeout_err && n < 40) begin
         if (gnt != '0) gseen++;
         @(negedge clk);
         n++;
      end
      chk("to_set_wins", 32'(timeout_err), 32'd1);
      clear_err = 1'b0;
      req = '0;
      repeat (2) @(negedge clk);
      chk("to_sticky", 32'(timeout_err), 32'd1);
      chk("to_no_gnt", 32'(gseen), 32'd0);
      clear_err = 1'b1;
      @(negedge clk);
      clear_err = 1'b0;
      chk("to_clear_alone", 32'(timeout_err), 32'd0);
      wait_busy(1'b0, "to_idle");

      // Stuck ack: no service until ack falls and passes the synchronizer.
      force_val = 1'b1;
      repeat (4) @(negedge clk);
      req = 4'b0001;
      bad = 0;
      repeat (6) begin
         @(negedge clk);
         if (busy || !spacer()) bad++;
      end
      chk("stuck_hold_idle", 32'(bad), 32'd0);
      force_en = 1'b0;
      n = 0;
      while (!busy && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("stuck_latency", 32'(n), 32'd3);
      chk("stuck_id", 32'(grant_id), 32'd0);
      wait_gnt("stuck_gnt_seen");
      chk("stuck_gnt", 32'(gnt), 32'b0001);
      req = '0;
      wait_busy(1'b0, "stuck_idle");

      // Reset mid-DATA; pointer is 1 beforehand so 4'b1001 would give 3 if it survived.
      req = 4'b1000;
      wait_busy(1'b1, "rstm_start");
      chk("rstm_id_before", 32'(grant_id), 32'd3);
      reset_n = 1'b0;
      #1;
      chk("rstm_spacer", 32'(spacer()), 32'd1);
      chk("rstm_gnt", 32'(gnt), 32'd0);
      chk("rstm_busy", 32'(busy), 32'd0);
      chk("rstm_err", 32'(timeout_err), 32'd0);
      req = 4'b1001;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      wait_busy(1'b1, "rstm_restart");
      chk("rstm_id_after", 32'(grant_id), 32'd0);
      wait_gnt("rstm_gnt_seen");
      chk("rstm_gnt", 32'(gnt), 32'b0001);
      req = '0;
      wait_busy(1'b0, "rstm_idle");

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

endmodule
